// File: rtl/vga_pkg.sv
// Shared constants for the VGA pattern controller: default 640x480@60 timing,
// pattern indices and the colour-bar table.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned PAT_BARS    = 0;
    localparam int unsigned PAT_CHECKER = 1;
    localparam int unsigned PAT_RAMP    = 2;
    localparam int unsigned PAT_WHITE   = 3;

    // {R,G,B} channel enables; element 0 is the leftmost bar (white), element 7 black
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, stable-level debouncer and one-cycle rising-edge pulse
// for an asynchronous push button.
module button_debouncer
    import vga_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_button,
    output logic o_rise
);

    localparam int unsigned      CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;

    // Level flips on the DEBOUNCE_CYCLES-th consecutive differing sample
    always_comb begin
        meta_d  = i_button;
        sync_d  = meta_q;
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign o_rise = rise_q;

endmodule

// File: rtl/vga_pattern_controller.sv
// Parametrised VGA top level: pixel clock-enable, timing generator, debounced
// buttons and a four-pattern image generator with frame-boundary commits.
module vga_pattern_controller
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE        = DEF_H_ACTIVE,
    parameter int unsigned H_FP            = DEF_H_FP,
    parameter int unsigned H_SYNC          = DEF_H_SYNC,
    parameter int unsigned H_BP            = DEF_H_BP,
    parameter int unsigned V_ACTIVE        = DEF_V_ACTIVE,
    parameter int unsigned V_FP            = DEF_V_FP,
    parameter int unsigned V_SYNC          = DEF_V_SYNC,
    parameter int unsigned V_BP            = DEF_V_BP,
    parameter bit          SYNC_POL        = 1'b0,
    parameter int unsigned CLK_DIV         = 2,
    parameter int unsigned COLOR_W         = 8,
    parameter int unsigned NUM_PATTERNS    = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                            i_CLK,
    input  logic                            i_RST_N,
    input  logic                            i_CYCLE_IMAGE,
    input  logic                            i_BLANK_DISPLAY,
    output logic [COLOR_W-1:0]              o_VGA_RED,
    output logic [COLOR_W-1:0]              o_VGA_GREEN,
    output logic [COLOR_W-1:0]              o_VGA_BLUE,
    output logic                            o_VGA_HSYNC,
    output logic                            o_VGA_VSYNC,
    output logic                            o_FRAME_START,
    output logic [$clog2(NUM_PATTERNS)-1:0] o_PATTERN
);

    localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned X_W        = $clog2(H_TOTAL);
    localparam int unsigned Y_W        = $clog2(V_TOTAL);
    localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PAT_W      = $clog2(NUM_PATTERNS);
    localparam int unsigned HS_START   = H_ACTIVE + H_FP;
    localparam int unsigned HS_END     = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START   = V_ACTIVE + V_FP;
    localparam int unsigned VS_END     = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PATTERNS - 1);

    logic [DIV_W-1:0]   div_q, div_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [COLOR_W-1:0] red_q, red_d;
    logic [COLOR_W-1:0] green_q, green_d;
    logic [COLOR_W-1:0] blue_q, blue_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               frame_start_q, frame_start_d;
    logic [PAT_W-1:0]   pattern_q, pattern_d;
    logic               blank_q, blank_d;
    logic               cycle_pend_q, cycle_pend_d;
    logic               blank_pend_q, blank_pend_d;

    logic               tick;
    logic               x_end, y_end;
    logic               commit;
    logic               cycle_rise, blank_rise;

    logic [31:0]        x_ext, y_ext;
    logic               in_active, hs_on, vs_on, checker_on;
    logic [2:0]         bar_idx, bar_rgb;
    logic [COLOR_W-1:0] ramp;
    logic [COLOR_W-1:0] pix_r, pix_g, pix_b;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cycle_btn (
        .i_clk   (i_CLK),
        .i_rst_n (i_RST_N),
        .i_button(i_CYCLE_IMAGE),
        .o_rise  (cycle_rise)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_blank_btn (
        .i_clk   (i_CLK),
        .i_rst_n (i_RST_N),
        .i_button(i_BLANK_DISPLAY),
        .o_rise  (blank_rise)
    );

    always_comb begin
        tick   = (div_q == DIV_LAST);
        div_d  = tick ? '0 : div_q + DIV_W'(1);
        x_end  = (x_q == X_LAST);
        y_end  = (y_q == Y_LAST);
        commit = tick & x_end & y_end;
        x_d    = x_q;
        y_d    = y_q;
        if (tick) begin
            if (x_end) begin
                x_d = '0;
                y_d = y_end ? '0 : y_q + Y_W'(1);
            end else begin
                x_d = x_q + X_W'(1);
            end
        end
    end

    // A rise on the commit tick survives because it is ORed in after the clear
    always_comb begin
        pattern_d    = pattern_q;
        blank_d      = blank_q;
        if (commit && cycle_pend_q) begin
            pattern_d = (pattern_q == PAT_LAST) ? '0 : pattern_q + PAT_W'(1);
        end
        if (commit && blank_pend_q) begin
            blank_d = ~blank_q;
        end
        cycle_pend_d = (cycle_pend_q & ~commit) | cycle_rise;
        blank_pend_d = (blank_pend_q & ~commit) | blank_rise;
    end

    always_comb begin
        x_ext      = 32'(x_q);
        y_ext      = 32'(y_q);
        in_active  = (x_ext < H_ACTIVE) && (y_ext < V_ACTIVE);
        hs_on      = (x_ext >= HS_START) && (x_ext < HS_END);
        vs_on      = (y_ext >= VS_START) && (y_ext < VS_END);
        bar_idx    = 3'((x_ext * 32'd8) / H_ACTIVE);
        bar_rgb    = BAR_RGB[bar_idx];
        checker_on = x_ext[5] ^ y_ext[5];
        ramp       = COLOR_W'(x_ext);
        pix_r      = '0;
        pix_g      = '0;
        pix_b      = '0;
        case (32'(pattern_q))
            PAT_BARS: begin
                pix_r = {COLOR_W{bar_rgb[2]}};
                pix_g = {COLOR_W{bar_rgb[1]}};
                pix_b = {COLOR_W{bar_rgb[0]}};
            end
            PAT_CHECKER: begin
                pix_r = {COLOR_W{checker_on}};
                pix_g = {COLOR_W{checker_on}};
                pix_b = {COLOR_W{checker_on}};
            end
            PAT_RAMP: begin
                pix_r = ramp;
                pix_g = ramp;
                pix_b = ramp;
            end
            PAT_WHITE: begin
                pix_r = '1;
                pix_g = '1;
                pix_b = '1;
            end
            default: begin
                pix_r = '0;
                pix_g = '0;
                pix_b = '0;
            end
        endcase
    end

    // Output stage samples the current (x,y) on the tick: one pixel of latency
    always_comb begin
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_start_d = tick && (x_q == '0) && (y_q == '0);
        if (tick) begin
            red_d   = (in_active && !blank_q) ? pix_r : '0;
            green_d = (in_active && !blank_q) ? pix_g : '0;
            blue_d  = (in_active && !blank_q) ? pix_b : '0;
            hsync_d = hs_on ? SYNC_POL : ~SYNC_POL;
            vsync_d = vs_on ? SYNC_POL : ~SYNC_POL;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            div_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
            pattern_q     <= '0;
            blank_q       <= 1'b0;
            cycle_pend_q  <= 1'b0;
            blank_pend_q  <= 1'b0;
        end else begin
            div_q         <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            pattern_q     <= pattern_d;
            blank_q       <= blank_d;
            cycle_pend_q  <= cycle_pend_d;
            blank_pend_q  <= blank_pend_d;
        end
    end

    assign o_VGA_RED     = red_q;
    assign o_VGA_GREEN   = green_q;
    assign o_VGA_BLUE    = blue_q;
    assign o_VGA_HSYNC   = hsync_q;
    assign o_VGA_VSYNC   = vsync_q;
    assign o_FRAME_START = frame_start_q;
    assign o_PATTERN     = pattern_q;

endmodule
